// File: rtl/dcache.sv
// Direct-mapped write-back data cache: 8 blocks x 4 bytes, blocking CPU interface.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | serving hits; a miss starts a refill
// S_WRITE_BACK | dirty victim block being written to memory
// S_FETCH      | requested block being read from memory
// S_UPDATE     | fill data, tag and valid written into the block
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_BACK,
        S_FETCH,
        S_UPDATE
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] data_mem [8];
    logic [2:0]  tag_mem  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;

    logic [2:0]  addr_tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        access;
    logic        hit;
    logic [31:0] cur_block;
    logic        mem_read;
    logic        mem_write;
    logic        write_hit;
    logic        fill;

    assign addr_tag  = ADDRESS[7:5];
    assign idx       = ADDRESS[4:2];
    assign off       = ADDRESS[1:0];
    assign access    = READ | WRITE;
    assign hit       = valid[idx] && (tag_mem[idx] == addr_tag);
    assign cur_block = data_mem[idx];
    assign READDATA  = cur_block[{off, 3'b000} +: 8];

    // Strobes and stall are forced low while reset is held, before the state register clears.
    assign BUSYWAIT  = !RESET && access && (!hit || (state != S_IDLE));
    assign MEM_READ  = mem_read && !RESET;
    assign MEM_WRITE = mem_write && !RESET;

    assign write_hit = !RESET && (state == S_IDLE) && WRITE && hit;
    assign fill      = !RESET && (state == S_UPDATE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        MEM_ADDRESS   = {addr_tag, idx};
        MEM_WRITEDATA = cur_block;
        case (state)
            S_IDLE: begin
                if (access && !hit) begin
                    next_state = dirty[idx] ? S_WRITE_BACK : S_FETCH;
                end
            end
            S_WRITE_BACK: begin
                mem_write   = 1'b1;
                MEM_ADDRESS = {tag_mem[idx], idx};
                if (!MEM_BUSYWAIT) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (write_hit) begin
            dirty[idx] <= 1'b1;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end
    end

    // Data and tags carry no reset; valid bits alone decide whether they mean anything.
    always_ff @(posedge CLK) begin
        if (write_hit) begin
            data_mem[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end else if (fill) begin
            data_mem[idx] <= MEM_READDATA;
            tag_mem[idx]  <= addr_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic        after_fill;

    // The first IDLE cycle after a fill resolves a miss already counted, so it is not a hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            after_fill <= 1'b0;
        end else begin
            after_fill <= (state == S_UPDATE);
            if ((state == S_IDLE) && access && hit && !after_fill && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if ((state == S_IDLE) && (next_state != S_IDLE) && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count;
    assign MISS_COUNT = miss_count;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random accesses against a
// block-level reference cache and a latency-modelled main memory.
module tb_dcache;
    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    dcache dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT(HIT_COUNT),
        .MISS_COUNT(MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] init_val(input int i);
        if (i == 1) return 32'hDDCCBBAA;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Main memory: busy for LAT cycles after any new request, then completes.
    logic [31:0] mem [64];
    logic        mem_loaded = 1'b0;
    logic [7:0]  sig;
    logic [7:0]  prev_sig = '0;
    int          mem_cnt = 0;
    logic [31:0] mem_rdata = '0;

    assign sig          = {MEM_READ, MEM_WRITE, MEM_ADDRESS};
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && ((sig != prev_sig) || (mem_cnt < LAT));
    assign MEM_READDATA = mem_rdata;

    always @(posedge CLK) begin
        prev_sig <= sig;
        mem_cnt  <= (sig != prev_sig) ? 1 : ((mem_cnt < 100) ? mem_cnt + 1 : mem_cnt);
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else begin
            if (MEM_READ && !MEM_BUSYWAIT) mem_rdata <= mem[MEM_ADDRESS];
            if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    // Reference model
    logic [31:0] ref_mem  [64];
    logic [31:0] ref_data [8];
    logic [2:0]  ref_tag  [8];
    logic [7:0]  ref_valid;
    logic [7:0]  ref_dirty;
    int          ref_hits;
    int          ref_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_valid = '0;
        ref_dirty = '0;
        ref_hits  = 0;
        ref_miss  = 0;
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        chk("hit_count", 32'(HIT_COUNT), 32'(ref_hits));
        chk("miss_count", 32'(MISS_COUNT), 32'(ref_miss));
`endif
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h04;
        WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busywait", 32'(BUSYWAIT), 32'd0);
        chk("reset_mem_read", 32'(MEM_READ), 32'd0);
        chk("reset_mem_write", 32'(MEM_WRITE), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ = 1'b0;
        model_reset();
        check_stats();
    endtask

    // One CPU access, held until BUSYWAIT falls; called just after a rising edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          output logic [7:0] rdata, output int busy_cyc, output logic wb_seen,
                          output logic [5:0] wb_addr, output logic [31:0] wb_data,
                          output logic [5:0] fetch_addr);
        logic [2:0] ix;
        logic [2:0] tg;
        logic [1:0] of;
        logic       exp_hit;
        logic       exp_wb;
        logic [5:0] exp_wb_addr;
        logic [31:0] exp_wb_data;
        logic       fetch_seen;
        ix = a[4:2];
        tg = a[7:5];
        of = a[1:0];
        exp_hit     = ref_valid[ix] && (ref_tag[ix] == tg);
        exp_wb      = !exp_hit && ref_dirty[ix];
        exp_wb_addr = {ref_tag[ix], ix};
        exp_wb_data = ref_data[ix];

        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = wd;
        busy_cyc = 0;
        wb_seen = 1'b0;
        fetch_seen = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        fetch_addr = '0;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && busy_cyc < 40) begin
            busy_cyc++;
            if (MEM_WRITE === 1'b1 && !wb_seen) begin
                wb_seen = 1'b1;
                wb_addr = MEM_ADDRESS;
                wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ === 1'b1) begin
                fetch_seen = 1'b1;
                fetch_addr = MEM_ADDRESS;
            end
            @(negedge CLK);
        end

        if (!exp_hit) begin
            if (exp_wb) ref_mem[exp_wb_addr] = exp_wb_data;
            ref_data[ix]  = ref_mem[a[7:2]];
            ref_tag[ix]   = tg;
            ref_valid[ix] = 1'b1;
            ref_dirty[ix] = 1'b0;
            ref_miss = (ref_miss < 65535) ? ref_miss + 1 : 65535;
        end else begin
            ref_hits = (ref_hits < 65535) ? ref_hits + 1 : 65535;
        end

        chk("busy_cycles", 32'(busy_cyc), exp_hit ? 32'd0 : (exp_wb ? 32'(2 * LAT + 4) : 32'(LAT + 3)));
        chk("readdata", 32'(READDATA), 32'(ref_data[ix][{of, 3'b000} +: 8]));
        chk("idle_strobes", 32'({MEM_READ, MEM_WRITE}), 32'd0);
        chk("writeback_seen", 32'(wb_seen), 32'(exp_wb));
        if (exp_wb) begin
            chk("wb_address", 32'(wb_addr), 32'(exp_wb_addr));
            chk("wb_data", wb_data, exp_wb_data);
        end
        chk("fetch_seen", 32'(fetch_seen), 32'(!exp_hit));
        if (!exp_hit) chk("fetch_address", 32'(fetch_addr), 32'(a[7:2]));
        rdata = READDATA;

        @(posedge CLK);
        #1;
        if (wr) begin
            ref_data[ix][{of, 3'b000} +: 8] = wd;
            ref_dirty[ix] = 1'b1;
        end
        READ = 1'b0;
        WRITE = 1'b0;
        check_stats();
    endtask

    initial begin
        logic [7:0]  rdv;
        int          bc;
        logic        wbs;
        logic [5:0]  wba;
        logic [31:0] wbd;
        logic [5:0]  fa;
        int          guard;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        model_reset();
        do_reset();

        access(1'b1, 1'b0, 8'h04, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("first_read_data", 32'(rdv), 32'hAA);
        chk("first_read_fetch_addr", 32'(fa), 32'h01);

        access(1'b1, 1'b0, 8'h07, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("hit_read_data", 32'(rdv), 32'hDD);
        chk("hit_read_stall", 32'(bc), 32'd0);

        access(1'b0, 1'b1, 8'h05, 8'h55, rdv, bc, wbs, wba, wbd, fa);
        chk("write_hit_stall", 32'(bc), 32'd0);

        access(1'b1, 1'b0, 8'hE5, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("evict_seen", 32'(wbs), 32'd1);
        chk("evict_addr", 32'(wba), 32'h01);
        chk("evict_data", wbd, 32'hDDCC55AA);
        chk("evict_fetch_addr", 32'(fa), 32'h39);

        access(1'b1, 1'b0, 8'h06, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        access(1'b1, 1'b1, 8'h06, 8'h77, rdv, bc, wbs, wba, wbd, fa);
        chk("rw_both_stall", 32'(bc), 32'd0);
        access(1'b1, 1'b0, 8'h06, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("rw_both_data", 32'(rdv), 32'h77);
        access(1'b1, 1'b0, 8'h26, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("rw_both_dirty", 32'(wbs), 32'd1);
        chk("rw_both_wb_byte", 32'(wbd[23:16]), 32'h77);

        // Reset pulsed while a fetch is outstanding
        READ = 1'b1;
        ADDRESS = 8'h14;
        guard = 0;
        @(negedge CLK);
        while (MEM_READ !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge CLK);
        end
        chk("fetch_reached", 32'(MEM_READ), 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("reset_fetch_mem_read", 32'(MEM_READ), 32'd0);
        chk("reset_fetch_busywait", 32'(BUSYWAIT), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("after_reset_mem_read", 32'(MEM_READ), 32'd0);
        @(posedge CLK);
        #1;
        check_stats();
        access(1'b1, 1'b0, 8'h04, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        chk("post_reset_miss", 32'(bc), 32'(LAT + 3));

        for (int n = 0; n < 200; n++) begin
            logic [2:0] t;
            logic [7:0] a;
            int         k;
            k = $urandom_range(0, 3);
            t = ($urandom_range(0, 2) == 2) ? 3'd7 : 3'($urandom_range(0, 1));
            a = {t, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(k != 1, k == 1 || k == 2, a, 8'($urandom), rdv, bc, wbs, wba, wbd, fa);
        end

`ifdef DCACHE_STATS_EN
        access(1'b1, 1'b0, 8'h04, 8'h00, rdv, bc, wbs, wba, wbd, fa);
        READ = 1'b1;
        ADDRESS = 8'h04;
        repeat (70000) @(posedge CLK);
        #1;
        READ = 1'b0;
        chk("hit_count_saturated", 32'(HIT_COUNT), 32'hFFFF);
        ref_hits = 65535;
        check_stats();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have input CLK (1 bit): system clock; all state updates occur on the rising edge.
REQ-002 The block SHALL have input RESET (1 bit): synchronous, active-high reset.
REQ-003 The block SHALL have input READ (1 bit): CPU byte-read request.
REQ-004 The block SHALL have input WRITE (1 bit): CPU byte-write request.
REQ-005 The block SHALL have input ADDRESS (8 bits): CPU byte address, split as tag[7:5], index[4:2], offset[1:0].
REQ-006 The block SHALL have input WRITEDATA (8 bits): CPU write byte.
REQ-007 The block SHALL have output READDATA (8 bits): selected cached byte.
REQ-008 The block SHALL have output BUSYWAIT (1 bit): stall to CPU and register file.
REQ-009 The block SHALL have outputs MEM_READ and MEM_WRITE (1 bit each): memory-side request strobes.
REQ-010 The block SHALL have output MEM_ADDRESS (6 bits): memory block address {tag, index}.
REQ-011 The block SHALL have output MEM_WRITEDATA (32 bits): write-back block, with byte0 in bits [7:0].
REQ-012 The block SHALL have inputs MEM_READDATA (32 bits) and MEM_BUSYWAIT (1 bit): memory fill data and memory stall.

Function
REQ-013 The cache SHALL be direct-mapped with 8 blocks of 4 bytes, each block carrying a 3-bit tag, a valid bit and a dirty bit.
REQ-014 Hit SHALL be the combinational result of valid[index] AND (tag[index] == ADDRESS[7:5]).
REQ-015 READDATA SHALL combinationally present byte [offset] of block [index].
REQ-016 BUSYWAIT SHALL be combinational: 1 when (READ or WRITE) and the access is not a hit or state is not IDLE; otherwise 0.
REQ-017 A read hit in IDLE SHALL complete in the same cycle with no stall.
REQ-018 A write hit in IDLE SHALL update the byte, set dirty and keep valid at the next rising edge, with BUSYWAIT 0.
REQ-019 When READ and WRITE are both high, the access SHALL be treated as a write; READDATA still shows the selected byte.
REQ-020 The FSM SHALL have four states: IDLE, WRITE_BACK, FETCH and UPDATE.
REQ-021 From IDLE, a miss SHALL transition to WRITE_BACK if dirty[index] is set, otherwise to FETCH.
REQ-022 In WRITE_BACK the block SHALL drive MEM_WRITE=1, MEM_ADDRESS={tag[index], index} and MEM_WRITEDATA=the stored block, and SHALL hold these until MEM_BUSYWAIT=0, then go to FETCH.
REQ-023 In FETCH the block SHALL drive MEM_READ=1 and MEM_ADDRESS=ADDRESS[7:2], and SHALL hold these until MEM_BUSYWAIT=0, then go to UPDATE.
REQ-024 In UPDATE, at the rising edge, the block SHALL write MEM_READDATA into the block, load the tag, set valid=1 and dirty=0, then go to IDLE.
REQ-025 Back in IDLE the pending access SHALL resolve as a hit, so that BUSYWAIT falls in the first IDLE cycle.
REQ-026 Outside WRITE_BACK and FETCH, MEM_READ and MEM_WRITE SHALL be 0 and MEM_ADDRESS and MEM_WRITEDATA SHALL be don't-care.
REQ-027 The CPU SHALL hold READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT=1; behaviour is unspecified otherwise.
REQ-028 A miss on tag wrap-around, for example 0xE4 replacing 0x04 at the same index, SHALL follow the same eviction path as any other miss.

Reset
REQ-029 While RESET=1 at a rising edge, the block SHALL clear all valid and dirty bits and set the state to IDLE.
REQ-030 While RESET=1, MEM_READ, MEM_WRITE and BUSYWAIT SHALL be 0.
REQ-031 Data and tag arrays need not be cleared on reset.
REQ-032 Reset asserted mid-WRITE_BACK or mid-FETCH SHALL abandon the memory transaction and discard dirty data, with MEM_READ and MEM_WRITE at 0 from the next cycle.

Configuration
REQ-033 With macro DCACHE_STATS_EN defined, the block SHALL add outputs HIT_COUNT and MISS_COUNT (16 bits each).
REQ-034 With DCACHE_STATS_EN defined, HIT_COUNT SHALL increment once per access resolved in IDLE without a preceding miss.
REQ-035 With DCACHE_STATS_EN defined, MISS_COUNT SHALL increment once per IDLE-to-WRITE_BACK or IDLE-to-FETCH transition.
REQ-036 With DCACHE_STATS_EN defined, both counters SHALL saturate at 0xFFFF and clear on RESET.
REQ-037 Without DCACHE_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Reset then READ 0x04, with memory block 0x01 = 0xDDCCBBAA and a 3-cycle MEM_BUSYWAIT -> required response: FETCH with MEM_ADDRESS=0x01, BUSYWAIT falls after UPDATE, READDATA=0xAA.
REQ-039 READ 0x07 immediately after -> required response: hit, BUSYWAIT=0 in the same cycle, READDATA=0xDD, no MEM_READ.
REQ-040 WRITE 0x55 to 0x05, then READ 0xE5 -> required response: dirty eviction with MEM_WRITE, MEM_ADDRESS=0x01, MEM_WRITEDATA=0xDDCC55AA, then FETCH with MEM_ADDRESS=0x39.
REQ-041 READ and WRITE both high, WRITEDATA=0x77, address 0x06 hit -> required response: byte updated to 0x77, dirty set, no stall.
REQ-042 RESET pulsed during FETCH -> required response: MEM_READ=0 next cycle, state IDLE, and a following READ 0x04 misses again.
REQ-043 With DCACHE_STATS_EN defined, run the above sequence -> required response: HIT_COUNT and MISS_COUNT match the scoreboard, and 70000 hits hold at 0xFFFF.
